// File: rtl/imm_pkg.sv
// imm_pkg
//   Shared types for the immediate decoder: RV32I base opcodes, the
//   immediate-format select code driven to the ALU source muxes, and the
//   opcode -> format/illegal decode used at the pipeline input.
package imm_pkg;

   typedef enum logic [6:0] {
      lw     = 7'd3,
      i_type = 7'd19,
      auipc  = 7'd23,
      sw     = 7'd35,
      r_type = 7'd51,
      lui    = 7'd55,
      beq    = 7'd99,
      jalr   = 7'd103,
      jal    = 7'd111
   } opcode_t;

   typedef enum logic [2:0] {
      IMM_I    = 3'b000,
      IMM_S    = 3'b001,
      IMM_B    = 3'b010,
      IMM_J    = 3'b011,
      IMM_U    = 3'b100,
      IMM_NONE = 3'b111
   } imm_src_t;

   typedef struct packed {
      imm_src_t src;
      logic     illegal;
   } dec_t;

   // R-type carries no immediate but is legal; lui/auipc are legal only
   // when U-type support is enabled.
   function automatic dec_t imm_decode(input logic [6:0] op, input logic enable_u);
      dec_t d;
      d.src     = IMM_NONE;
      d.illegal = 1'b1;
      case (op)
         lw, i_type, jalr: begin d.src = IMM_I; d.illegal = 1'b0; end
         sw:               begin d.src = IMM_S; d.illegal = 1'b0; end
         beq:              begin d.src = IMM_B; d.illegal = 1'b0; end
         jal:              begin d.src = IMM_J; d.illegal = 1'b0; end
         lui, auipc: begin
            if (enable_u) begin
               d.src     = IMM_U;
               d.illegal = 1'b0;
            end
         end
         r_type:           d.illegal = 1'b0;
         default:          ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/imm_decode_pipe_if.sv
// imm_decode_pipe_if
//   Instruction-in / decoded-immediate-out handshake bundle.
//   i_Valid/o_Ready/i_Instr : upstream (fetch) side
//   o_Valid/i_Ready         : downstream (ALU source mux) side
//   o_ImmSrc/o_ImmExt/o_Illegal : decoded bundle, o_IllegalCnt : illegal tally
//   slave  = decoder side, master = driver side.
interface imm_decode_pipe_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             i_Valid;
   logic             o_Ready;
   logic [31:0]      i_Instr;
   logic             o_Valid;
   logic             i_Ready;
   logic [2:0]       o_ImmSrc;
   logic [XLEN-1:0]  o_ImmExt;
   logic             o_Illegal;
   logic [CNT_W-1:0] o_IllegalCnt;

   modport slave (
      input  i_Valid, i_Instr, i_Ready,
      output o_Ready, o_Valid, o_ImmSrc, o_ImmExt, o_Illegal, o_IllegalCnt
   );

   modport master (
      output i_Valid, i_Instr, i_Ready,
      input  o_Ready, o_Valid, o_ImmSrc, o_ImmExt, o_Illegal, o_IllegalCnt
   );
endinterface

// File: rtl/imm_extend.sv
// imm_extend
//   Combinational immediate builder.
//   instr : instruction word (opcode bits ignored, format comes from src)
//   src   : immediate format select
//   imm   : immediate sign-extended from instr[31] to XLEN (0 for IMM_NONE)
module imm_extend
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  imm_src_t        src,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;
   logic        unused_opcode;

   assign unused_opcode = ^instr[6:0];

   always_comb begin
      case (src)
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
         IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm[31:0] = imm32;

   generate
      if (XLEN > 32) begin : g_wide
         assign imm[XLEN-1:32] = {(XLEN-32){imm32[31]}};
      end
   endgenerate

endmodule

// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe
//   Pipelined RV32I immediate decoder behind an elastic valid/ready pipe.
//   i_Clk   : clock, rising edge
//   i_Reset : asynchronous active-high reset, flushes all in-flight entries
//   bus     : handshake bundle (see imm_decode_pipe_if), decoder side
//   Latency PIPE_STAGES (1 or 2); full throughput; no skid buffer, so
//   o_Ready is combinational from i_Ready.
module imm_decode_pipe
   import imm_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int PIPE_STAGES = 1,
   parameter int ENABLE_U    = 1,
   parameter int CNT_W       = 16
) (
   input logic               i_Clk,
   input logic               i_Reset,
   imm_decode_pipe_if.slave  bus
);

   dec_t             dec_in;
   logic             rdy1;
   logic [31:0]      ext_instr;
   imm_src_t         ext_src;
   logic [XLEN-1:0]  ext_imm;
   logic             out_v;
   imm_src_t         out_src;
   logic [XLEN-1:0]  out_imm;
   logic             out_ill;
   logic [CNT_W-1:0] cnt;

   assign dec_in = imm_decode(bus.i_Instr[6:0], ENABLE_U != 0);

   imm_extend #(.XLEN(XLEN)) u_extend (
      .instr (ext_instr),
      .src   (ext_src),
      .imm   (ext_imm)
   );

   generate
      if ((PIPE_STAGES != 1 && PIPE_STAGES != 2) || (XLEN != 32 && XLEN != 64)) begin : g_bad_cfg
         $error("imm_decode_pipe: PIPE_STAGES must be 1 or 2 and XLEN 32 or 64");
      end else if (PIPE_STAGES == 1) begin : g_one
         // Decode and extend both happen ahead of the single register.
         assign ext_instr = bus.i_Instr;
         assign ext_src   = dec_in.src;
         assign rdy1      = !out_v || bus.i_Ready;

         always_ff @(posedge i_Clk or posedge i_Reset) begin
            if (i_Reset) begin
               out_v   <= 1'b0;
               out_src <= IMM_NONE;
               out_imm <= '0;
               out_ill <= 1'b0;
            end else if (rdy1) begin
               out_v <= bus.i_Valid;
               if (bus.i_Valid) begin
                  out_src <= dec_in.src;
                  out_ill <= dec_in.illegal;
                  out_imm <= ext_imm;
               end
            end
         end
      end else begin : g_two
         logic        s1_v;
         logic [31:0] s1_instr;
         imm_src_t    s1_src;
         logic        s1_ill;
         logic        rdy2;

         // Stage 1 holds the raw word plus decode; extension runs in stage 2.
         assign ext_instr = s1_instr;
         assign ext_src   = s1_src;
         assign rdy2      = !out_v || bus.i_Ready;
         assign rdy1      = !s1_v || rdy2;

         always_ff @(posedge i_Clk or posedge i_Reset) begin
            if (i_Reset) begin
               s1_v     <= 1'b0;
               s1_instr <= '0;
               s1_src   <= IMM_NONE;
               s1_ill   <= 1'b0;
            end else if (rdy1) begin
               s1_v <= bus.i_Valid;
               if (bus.i_Valid) begin
                  s1_instr <= bus.i_Instr;
                  s1_src   <= dec_in.src;
                  s1_ill   <= dec_in.illegal;
               end
            end
         end

         always_ff @(posedge i_Clk or posedge i_Reset) begin
            if (i_Reset) begin
               out_v   <= 1'b0;
               out_src <= IMM_NONE;
               out_imm <= '0;
               out_ill <= 1'b0;
            end else if (rdy2) begin
               out_v <= s1_v;
               if (s1_v) begin
                  out_src <= s1_src;
                  out_ill <= s1_ill;
                  out_imm <= ext_imm;
               end
            end
         end
      end
   endgenerate

   // Counted on acceptance at the input, so flushed entries still count.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         cnt <= '0;
      end else if (bus.i_Valid && rdy1 && dec_in.illegal && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign bus.o_Ready      = rdy1;
   assign bus.o_Valid      = out_v;
   assign bus.o_ImmSrc     = out_src;
   assign bus.o_ImmExt     = out_imm;
   assign bus.o_Illegal    = out_ill;
   assign bus.o_IllegalCnt = cnt;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// tb_imm_decode_pipe
//   Two decoder instances: A (XLEN=32, 1 stage, U enabled, 16-bit counter)
//   and B (XLEN=64, 2 stages, U disabled, 2-bit counter). Directed cases
//   with hand-derived constants, then a randomized run against a queue model.
module tb_imm_decode_pipe;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   imm_decode_pipe_if #(.XLEN(32), .CNT_W(16)) a_if ();
   imm_decode_pipe_if #(.XLEN(64), .CNT_W(2))  b_if ();

   imm_decode_pipe #(.XLEN(32), .PIPE_STAGES(1), .ENABLE_U(1), .CNT_W(16)) dut_a (
      .i_Clk(clk), .i_Reset(rst), .bus(a_if.slave));

   imm_decode_pipe #(.XLEN(64), .PIPE_STAGES(2), .ENABLE_U(0), .CNT_W(2)) dut_b (
      .i_Clk(clk), .i_Reset(rst), .bus(b_if.slave));

   typedef struct {
      logic [2:0]  src;
      logic [63:0] imm;
      logic        ill;
   } exp_t;

   // Reference decode: immediates built as signed integers with arithmetic.
   function automatic exp_t ref_dec(input logic [31:0] ins, input bit en_u);
      exp_t   e;
      longint v;
      v     = 0;
      e.src = 3'b111;
      e.ill = 1'b0;
      case (ins[6:0])
         7'd3, 7'd19, 7'd103: begin e.src = 3'd0; v = longint'($signed(ins[31:20])); end
         7'd35:  begin e.src = 3'd1; v = longint'($signed({ins[31:25], ins[11:7]})); end
         7'd99:  begin e.src = 3'd2;
                       v = 2 * longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})); end
         7'd111: begin e.src = 3'd3;
                       v = 2 * longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})); end
         7'd55, 7'd23: begin
            if (en_u) begin e.src = 3'd4; v = longint'($signed(ins[31:12])) * 4096; end
            else e.ill = 1'b1;
         end
         7'd51:   ;
         default: e.ill = 1'b1;
      endcase
      e.imm = v;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 10))
         0: w[6:0] = 7'd3;   1: w[6:0] = 7'd19;  2: w[6:0] = 7'd103;
         3: w[6:0] = 7'd35;  4: w[6:0] = 7'd99;  5: w[6:0] = 7'd111;
         6: w[6:0] = 7'd55;  7: w[6:0] = 7'd23;  8: w[6:0] = 7'd51;
         9: w[6:0] = 7'd127;
         default: ;
      endcase
      return w;
   endfunction

   task automatic set_idle();
      a_if.i_Valid = 1'b0; a_if.i_Instr = '0; a_if.i_Ready = 1'b1;
      b_if.i_Valid = 1'b0; b_if.i_Instr = '0; b_if.i_Ready = 1'b1;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (a_if.o_Valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid: got %b want 0", a_if.o_Valid); end
      checks++; if (a_if.o_ImmSrc !== 3'b111) begin errors++; $display("FAIL rst_a_src: got %b want 111", a_if.o_ImmSrc); end
      checks++; if (a_if.o_ImmExt !== 32'h0) begin errors++; $display("FAIL rst_a_imm: got %h want 0", a_if.o_ImmExt); end
      checks++; if (a_if.o_Illegal !== 1'b0) begin errors++; $display("FAIL rst_a_ill: got %b want 0", a_if.o_Illegal); end
      checks++; if (a_if.o_IllegalCnt !== 16'd0) begin errors++; $display("FAIL rst_a_cnt: got %0d want 0", a_if.o_IllegalCnt); end
      checks++; if (a_if.o_Ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready: got %b want 1", a_if.o_Ready); end
      checks++; if (b_if.o_Valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid: got %b want 0", b_if.o_Valid); end
      checks++; if (b_if.o_ImmSrc !== 3'b111) begin errors++; $display("FAIL rst_b_src: got %b want 111", b_if.o_ImmSrc); end
      checks++; if (b_if.o_ImmExt !== 64'h0) begin errors++; $display("FAIL rst_b_imm: got %h want 0", b_if.o_ImmExt); end
      checks++; if (b_if.o_IllegalCnt !== 2'd0) begin errors++; $display("FAIL rst_b_cnt: got %0d want 0", b_if.o_IllegalCnt); end
      checks++; if (b_if.o_Ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready: got %b want 1", b_if.o_Ready); end
   endtask

   task automatic test_lw_latency();
      @(negedge clk);
      a_if.i_Valid = 1'b1; a_if.i_Instr = 32'hFFC12083;
      b_if.i_Valid = 1'b1; b_if.i_Instr = 32'hFFC12083;
      @(posedge clk); #1;
      checks++; if (a_if.o_Valid !== 1'b1) begin errors++; $display("FAIL lw_a_valid: got %b want 1", a_if.o_Valid); end
      checks++; if (a_if.o_ImmSrc !== 3'b000) begin errors++; $display("FAIL lw_a_src: got %b want 000", a_if.o_ImmSrc); end
      checks++; if (a_if.o_ImmExt !== 32'hFFFFFFFC) begin errors++; $display("FAIL lw_a_imm: got %h want fffffffc", a_if.o_ImmExt); end
      checks++; if (a_if.o_Illegal !== 1'b0) begin errors++; $display("FAIL lw_a_ill: got %b want 0", a_if.o_Illegal); end
      checks++; if (b_if.o_Valid !== 1'b0) begin errors++; $display("FAIL lw_b_early: got %b want 0", b_if.o_Valid); end
      @(negedge clk);
      set_idle();
      @(posedge clk); #1;
      checks++; if (b_if.o_Valid !== 1'b1) begin errors++; $display("FAIL lw_b_valid: got %b want 1", b_if.o_Valid); end
      checks++; if (b_if.o_ImmExt !== 64'hFFFFFFFFFFFFFFFC) begin errors++; $display("FAIL lw_b_imm64: got %h want fffffffffffffffc", b_if.o_ImmExt); end
      checks++; if (a_if.o_Valid !== 1'b0) begin errors++; $display("FAIL lw_a_drain: got %b want 0", a_if.o_Valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      b_if.i_Valid = 1'b1; b_if.i_Instr = 32'h00502423;
      @(negedge clk);
      b_if.i_Instr = 32'hFE000CE3;
      @(posedge clk); #1;
      checks++; if (b_if.o_Valid !== 1'b1) begin errors++; $display("FAIL b2b_sw_valid: got %b want 1", b_if.o_Valid); end
      checks++; if (b_if.o_ImmSrc !== 3'b001) begin errors++; $display("FAIL b2b_sw_src: got %b want 001", b_if.o_ImmSrc); end
      checks++; if (b_if.o_ImmExt !== 64'h8) begin errors++; $display("FAIL b2b_sw_imm: got %h want 8", b_if.o_ImmExt); end
      @(negedge clk);
      set_idle();
      @(posedge clk); #1;
      checks++; if (b_if.o_Valid !== 1'b1) begin errors++; $display("FAIL b2b_beq_valid: got %b want 1", b_if.o_Valid); end
      checks++; if (b_if.o_ImmSrc !== 3'b010) begin errors++; $display("FAIL b2b_beq_src: got %b want 010", b_if.o_ImmSrc); end
      checks++; if (b_if.o_ImmExt !== 64'hFFFFFFFFFFFFFFF8) begin errors++; $display("FAIL b2b_beq_imm: got %h want fffffffffffffff8", b_if.o_ImmExt); end
      @(posedge clk); #1;
      checks++; if (b_if.o_Valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", b_if.o_Valid); end
   endtask

   task automatic test_stall();
      int xfers;
      @(negedge clk);
      a_if.i_Valid = 1'b1; a_if.i_Instr = 32'h001000EF; a_if.i_Ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (a_if.o_Valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, a_if.o_Valid); end
         checks++; if (a_if.o_ImmSrc !== 3'b011) begin errors++; $display("FAIL stall_src[%0d]: got %b want 011", i, a_if.o_ImmSrc); end
         checks++; if (a_if.o_ImmExt !== 32'h00000800) begin errors++; $display("FAIL stall_imm[%0d]: got %h want 00000800", i, a_if.o_ImmExt); end
         checks++; if (a_if.o_Ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", i, a_if.o_Ready); end
         @(negedge clk);
         a_if.i_Valid = 1'b0;
      end
      a_if.i_Ready = 1'b1;
      xfers = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (a_if.o_Valid && a_if.i_Ready) xfers++;
         @(negedge clk);
      end
      checks++; if (xfers != 1) begin errors++; $display("FAIL stall_release_xfers: got %0d want 1", xfers); end
   endtask

   task automatic test_lui();
      @(negedge clk);
      a_if.i_Valid = 1'b1; a_if.i_Instr = 32'h123450B7;
      b_if.i_Valid = 1'b1; b_if.i_Instr = 32'h123450B7;
      @(posedge clk); #1;
      checks++; if (a_if.o_ImmSrc !== 3'b100) begin errors++; $display("FAIL lui_a_src: got %b want 100", a_if.o_ImmSrc); end
      checks++; if (a_if.o_ImmExt !== 32'h12345000) begin errors++; $display("FAIL lui_a_imm: got %h want 12345000", a_if.o_ImmExt); end
      checks++; if (a_if.o_Illegal !== 1'b0) begin errors++; $display("FAIL lui_a_ill: got %b want 0", a_if.o_Illegal); end
      checks++; if (b_if.o_IllegalCnt !== 2'd1) begin errors++; $display("FAIL lui_b_cnt: got %0d want 1", b_if.o_IllegalCnt); end
      @(negedge clk);
      set_idle();
      @(posedge clk); #1;
      checks++; if (b_if.o_Valid !== 1'b1) begin errors++; $display("FAIL lui_b_valid: got %b want 1", b_if.o_Valid); end
      checks++; if (b_if.o_ImmSrc !== 3'b111) begin errors++; $display("FAIL lui_b_src: got %b want 111", b_if.o_ImmSrc); end
      checks++; if (b_if.o_Illegal !== 1'b1) begin errors++; $display("FAIL lui_b_ill: got %b want 1", b_if.o_Illegal); end
      checks++; if (b_if.o_ImmExt !== 64'h0) begin errors++; $display("FAIL lui_b_imm: got %h want 0", b_if.o_ImmExt); end
      @(posedge clk); #1;
   endtask

   task automatic test_counter_sat();
      int want;
      test_reset();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         b_if.i_Valid = 1'b1; b_if.i_Instr = 32'h0000007F;
         @(posedge clk); #1;
         want = (k > 3) ? 3 : k;
         checks++; if (b_if.o_IllegalCnt !== want[1:0]) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, b_if.o_IllegalCnt, want); end
      end
      @(negedge clk);
      set_idle();
      a_if.i_Valid = 1'b1; a_if.i_Instr = 32'h002081B3;
      @(posedge clk); #1;
      checks++; if (a_if.o_ImmSrc !== 3'b111) begin errors++; $display("FAIL rtype_src: got %b want 111", a_if.o_ImmSrc); end
      checks++; if (a_if.o_ImmExt !== 32'h0) begin errors++; $display("FAIL rtype_imm: got %h want 0", a_if.o_ImmExt); end
      checks++; if (a_if.o_Illegal !== 1'b0) begin errors++; $display("FAIL rtype_ill: got %b want 0", a_if.o_Illegal); end
      checks++; if (a_if.o_IllegalCnt !== 16'd0) begin errors++; $display("FAIL rtype_cnt: got %0d want 0", a_if.o_IllegalCnt); end
      @(negedge clk);
      set_idle();
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      b_if.i_Valid = 1'b1; b_if.i_Instr = 32'h0000007F; b_if.i_Ready = 1'b0;
      @(negedge clk);
      b_if.i_Instr = 32'h0000107F;
      @(posedge clk); #1;
      checks++; if (b_if.o_Valid !== 1'b1) begin errors++; $display("FAIL mid_full_valid: got %b want 1", b_if.o_Valid); end
      checks++; if (b_if.o_Ready !== 1'b0) begin errors++; $display("FAIL mid_full_ready: got %b want 0", b_if.o_Ready); end
      @(negedge clk);
      b_if.i_Valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if (b_if.o_Valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", b_if.o_Valid); end
      checks++; if (b_if.o_IllegalCnt !== 2'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d want 0", b_if.o_IllegalCnt); end
      @(negedge clk);
      rst = 1'b0;
      b_if.i_Ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++; if (b_if.o_Valid !== 1'b0) begin errors++; $display("FAIL mid_ghost[%0d]: got %b want 0", i, b_if.o_Valid); end
      end
   endtask

   task automatic test_random();
      exp_t qa[$];
      exp_t qb[$];
      exp_t e;
      int   cnt_a;
      int   cnt_b;
      test_reset();
      cnt_a = 0;
      cnt_b = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         a_if.i_Valid = ($urandom_range(0, 9) < 7); a_if.i_Instr = rand_instr();
         a_if.i_Ready = ($urandom_range(0, 9) < 7);
         b_if.i_Valid = ($urandom_range(0, 9) < 7); b_if.i_Instr = rand_instr();
         b_if.i_Ready = ($urandom_range(0, 9) < 7);
         #1;
         // A holds at most one entry, B at most two; ready only drops when full.
         checks++; if (a_if.o_Ready !== (qa.size() < 1 || a_if.i_Ready)) begin errors++; $display("FAIL rand_a_ready[%0d]: got %b occ %0d", cyc, a_if.o_Ready, qa.size()); end
         checks++; if (b_if.o_Ready !== (qb.size() < 2 || b_if.i_Ready)) begin errors++; $display("FAIL rand_b_ready[%0d]: got %b occ %0d", cyc, b_if.o_Ready, qb.size()); end
         checks++; if (a_if.o_Valid !== (qa.size() > 0)) begin errors++; $display("FAIL rand_a_valid[%0d]: got %b occ %0d", cyc, a_if.o_Valid, qa.size()); end
         if (a_if.o_Valid && a_if.i_Ready) begin
            checks++;
            if (qa.size() == 0) begin errors++; $display("FAIL rand_a_dup[%0d]: output with empty model", cyc); end
            else begin
               e = qa.pop_front();
               if (a_if.o_ImmSrc !== e.src || a_if.o_ImmExt !== e.imm[31:0] || a_if.o_Illegal !== e.ill) begin
                  errors++;
                  $display("FAIL rand_a_data[%0d]: got %b/%h/%b want %b/%h/%b", cyc, a_if.o_ImmSrc, a_if.o_ImmExt, a_if.o_Illegal, e.src, e.imm[31:0], e.ill);
               end
            end
         end
         if (b_if.o_Valid && b_if.i_Ready) begin
            checks++;
            if (qb.size() == 0) begin errors++; $display("FAIL rand_b_dup[%0d]: output with empty model", cyc); end
            else begin
               e = qb.pop_front();
               if (b_if.o_ImmSrc !== e.src || b_if.o_ImmExt !== e.imm || b_if.o_Illegal !== e.ill) begin
                  errors++;
                  $display("FAIL rand_b_data[%0d]: got %b/%h/%b want %b/%h/%b", cyc, b_if.o_ImmSrc, b_if.o_ImmExt, b_if.o_Illegal, e.src, e.imm, e.ill);
               end
            end
         end
         if (a_if.i_Valid && a_if.o_Ready) begin
            e = ref_dec(a_if.i_Instr, 1'b1);
            qa.push_back(e);
            if (e.ill && cnt_a < 65535) cnt_a++;
         end
         if (b_if.i_Valid && b_if.o_Ready) begin
            e = ref_dec(b_if.i_Instr, 1'b0);
            qb.push_back(e);
            if (e.ill && cnt_b < 3) cnt_b++;
         end
         @(posedge clk); #1;
         checks++; if (a_if.o_IllegalCnt !== cnt_a[15:0]) begin errors++; $display("FAIL rand_a_cnt[%0d]: got %0d want %0d", cyc, a_if.o_IllegalCnt, cnt_a); end
         checks++; if (b_if.o_IllegalCnt !== cnt_b[1:0]) begin errors++; $display("FAIL rand_b_cnt[%0d]: got %0d want %0d", cyc, b_if.o_IllegalCnt, cnt_b); end
      end
      @(negedge clk);
      set_idle();
      for (int i = 0; i < 6; i++) begin
         #1;
         if (a_if.o_Valid && qa.size() > 0) begin
            e = qa.pop_front();
            checks++; if (a_if.o_ImmExt !== e.imm[31:0]) begin errors++; $display("FAIL drain_a_imm: got %h want %h", a_if.o_ImmExt, e.imm[31:0]); end
         end
         if (b_if.o_Valid && qb.size() > 0) begin
            e = qb.pop_front();
            checks++; if (b_if.o_ImmExt !== e.imm) begin errors++; $display("FAIL drain_b_imm: got %h want %h", b_if.o_ImmExt, e.imm); end
         end
         @(negedge clk);
      end
      checks++; if (qa.size() != 0 || a_if.o_Valid !== 1'b0) begin errors++; $display("FAIL drain_a_left: got %0d entries valid %b want 0", qa.size(), a_if.o_Valid); end
      checks++; if (qb.size() != 0 || b_if.o_Valid !== 1'b0) begin errors++; $display("FAIL drain_b_left: got %0d entries valid %b want 0", qb.size(), b_if.o_Valid); end
   endtask

   initial begin
      rst = 1'b1;
      set_idle();
      test_reset();
      test_lw_latency();
      test_back_to_back();
      test_stall();
      test_reset();
      test_lui();
      test_counter_sat();
      test_reset_midstream();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule

// File: doc/imm_decode_pipe.md
Name: imm_decode_pipe

Overview:
- Parametrised, pipelined immediate decoder/extender for the RISC-V core.
- Covers all RV32I immediate formats (I, S, B, J, U) plus R-type.
- Accepts a fetched instruction over a valid/ready handshake and returns the format select, the sign-extended immediate and an illegal-opcode flag after PIPE_STAGES cycles.
- Sits between the instruction register and the ALU source muxes; downstream stalls back-pressure fetch through the handshake.

Parameters:
- XLEN, 32, datapath width: 32 or 64; the immediate is sign-extended to XLEN.
- PIPE_STAGES, 1, latency in cycles: 1 or 2; any other value is an elaboration error.
- ENABLE_U, 1, when 1, lui/auipc decode as U-type; when 0, they are illegal.
- CNT_W, 16, width of the saturating illegal-opcode counter.

Ports:
- i_Clk  input  1  clock, rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Valid  input  1  i_Instr is valid this cycle.
- o_Ready  output  1  block accepts i_Instr this cycle.
- i_Instr  input  32  instruction word.
- o_Valid  output  1  output bundle valid.
- i_Ready  input  1  downstream accepts the output bundle.
- o_ImmSrc  output  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 111 none.
- o_ImmExt  output  XLEN  sign-extended immediate.
- o_Illegal  output  1  opcode not recognised.
- o_IllegalCnt  output  CNT_W  count of illegal instructions accepted.

Behaviour:
- Decode by opcode i_Instr[6:0]:
  - 3 (lw), 19 (op-imm), 103 (jalr) -> I.
  - 35 (sw) -> S.
  - 99 (branch) -> B.
  - 111 (jal) -> J.
  - 55 (lui), 23 (auipc) -> U, when ENABLE_U=1.
  - 51 (r-type) -> 111 with ImmExt 0 and Illegal 0.
  - Anything else -> 111 with ImmExt 0 and Illegal 1.
- Immediate construction:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - U: sext({instr[31:12], 12'b0}).
  - Sign bit is always instr[31]; with XLEN=64, bits 63:32 replicate it.
- Handshake:
  - A transfer occurs on any rising edge where valid and ready are both high.
  - Each stage k is an elastic register: ready_k = !valid_k || ready_(k+1).
  - The last stage takes i_Ready as its downstream ready.
  - o_Ready is ready_1 and is combinational from i_Ready; there is no skid buffer.
- Latency and throughput:
  - An accepted instruction appears on o_Valid exactly PIPE_STAGES cycles later if i_Ready stays high.
  - Throughput is 1 per cycle.
- PIPE_STAGES=2 split:
  - Stage 1 registers the instruction word and the decoded ImmSrc/Illegal.
  - Stage 2 registers the extended immediate.
- Stall: while o_Valid=1 and i_Ready=0, o_ImmSrc, o_ImmExt and o_Illegal hold stable. No accepted instruction may be dropped or duplicated.
- Bubbles: when o_Valid=0, output data holds its last value and must not be consumed.
- Illegal counter:
  - Increments by 1 in the cycle an illegal instruction is accepted at the input, not at the output.
  - Saturates at 2^CNT_W-1.
- Reset, applied asynchronously (including mid-operation):
  - All stage valids -> 0; in-flight instructions are discarded.
  - o_ImmSrc -> 111, o_ImmExt -> 0, o_Illegal -> 0, o_IllegalCnt -> 0.
  - o_Ready is 1 in the first cycle after reset deasserts.
- Simultaneous events: a stage holding data whose downstream accepts can load new data in the same cycle (full throughput when unstalled).

Decomposition:
- Shared package imm_pkg:
  - opcode_t enum (lw=3, sw=35, r_type=51, i_type=19, jal=111, beq=99, jalr=103, lui=55, auipc=23).
  - imm_src_t enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_NONE).
- One combinational sub-module, imm_extend: takes instr and imm_src_t, returns the XLEN immediate.
- Pipeline registers, handshake and counter stay in imm_decode_pipe.

Test Plan:
- lw x1,-4(x2), 0xFFC12083, PIPE_STAGES=1, i_Ready=1 -> next cycle o_Valid=1, ImmSrc=000, ImmExt=0xFFFFFFFC, Illegal=0.
- Back-to-back sw 0x00502423 then beq 0xFE000CE3, PIPE_STAGES=2 -> cycles +2/+3 give S/0x00000008, then B/0xFFFFFFF8.
- jal 0x001000EF, i_Ready held 0 for 3 cycles -> ImmSrc=011, ImmExt=0x00000800 stable throughout; o_Ready=0 once the pipe is full; exactly one transfer after release.
- lui 0x123450B7 with ENABLE_U=1 -> U, 0x12345000. With ENABLE_U=0 -> 111, Illegal=1, IllegalCnt +1.
- 0x0000007F x3 with CNT_W=2 -> IllegalCnt 1, 2, 3, then stays 3 after a 4th illegal; R-type 0x002081B3 -> 111, ImmExt=0, Illegal=0.
- Assert i_Reset mid-stream with 2 instructions in flight -> o_Valid=0 immediately, counter 0, neither instruction emitted after reset release; XLEN=64 lw 0xFFC12083 -> 0xFFFFFFFFFFFFFFFC.
